// File: rtl/lector_bus.sv
// Receiving end of the shared tri-state data bus. It decodes chip-select, waits out the
// driver turnaround, and queues the sampled words with end-of-burst tags in a small FIFO.
module lector_bus #(
    parameter int unsigned          DATA_W = 4,
    parameter int unsigned          CS_W   = 5,
    parameter logic [CS_W-1:0]      RD_CS  = 5'b11000,
    parameter int unsigned          TURN   = 1,
    parameter int unsigned          DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [CS_W-1:0]          cs,
    input  logic [DATA_W-1:0]        datbus,
    output logic [DATA_W-1:0]        dato,
    output logic                     dato_ultimo,
    output logic                     dato_valid,
    input  logic                     dato_ready,
    output logic                     en_rafaga,
    output logic                     vacio,
    output logic                     lleno,
    output logic [$clog2(DEPTH):0]   cuenta,
    output logic                     desborde,
    input  logic                     clr_desborde
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {INACTIVO, RAFAGA} state_t;

    state_t            state_q, state_d;
    logic [TURN:1]     m_q, m_d;
    logic [TURN:0]     m;
    logic [DATA_W:0]   mem_q [DEPTH];
    logic [DATA_W:0]   mem_d [DEPTH];
    logic [DATA_W:0]   head_q, head_d;
    logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              desb_q, desb_d;
    logic              sel, push, ultimo, pop, full, push_ok, drop;
    logic [DATA_W:0]   word;

    always_comb begin
        sel     = (cs == RD_CS);
        m       = {m_q, sel};
        m_d     = m[TURN-1:0];
        push    = m[TURN];
        ultimo  = m[TURN] & ~m[TURN-1];
        word    = {ultimo, datbus};
        pop     = (cnt_q != '0) & dato_ready;
        full    = (cnt_q == FULL);
        push_ok = push & (~full | pop);
        drop    = push & full & ~pop;

        wr_d  = wr_q + PW'(push_ok);
        rd_d  = rd_q + PW'(pop);
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop);

        for (int unsigned i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        if (push_ok) mem_d[wr_q] = word;

        // Head register looks ahead to the post-edge head; bypass covers a word landing in
        // the slot that becomes the head on this same edge.
        if (cnt_d == '0)
            head_d = '0;
        else if (push_ok && (wr_q == rd_d))
            head_d = word;
        else
            head_d = mem_q[rd_d];

        state_d = state_q;
        if (m_d[TURN] && !m_q[TURN])
            state_d = RAFAGA;
        else if (push && ultimo)
            state_d = INACTIVO;

        desb_d = desb_q;
        if (drop)
            desb_d = 1'b1;
        else if (clr_desborde)
            desb_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INACTIVO;
            m_q     <= '0;
            head_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            desb_q  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            head_q  <= head_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            desb_q  <= desb_d;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign dato        = head_q[DATA_W-1:0];
    assign dato_ultimo = head_q[DATA_W];
    assign dato_valid  = (cnt_q != '0);
    assign vacio       = (cnt_q == '0);
    assign lleno       = (cnt_q == FULL);
    assign cuenta      = cnt_q;
    assign desborde    = desb_q;
    assign en_rafaga   = (state_q == RAFAGA);

`ifndef SYNTHESIS
    a_bus_known: assert property (@(posedge clk) disable iff (!rst_n)
        m_q[TURN] |-> !$isunknown(datbus));
`endif

endmodule

// File: tb/tb_lector_bus.sv
// Directed bench for lector_bus: per-cycle vector table plus hand sequences for idle
// decode and asynchronous reset mid-burst.
module tb_lector_bus;

    localparam logic [4:0] RD = 5'b11000;
    localparam logic [4:0] ID = 5'b00000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] cs = ID;
    logic [3:0] bus = 4'h0;
    logic       rdy = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] dato;
    logic       ult, vld, raf, vacio, lleno, desb;
    logic [2:0] cuenta;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] cs;
        logic [3:0] bus;
        logic       rdy;
        logic       clr;
        logic [3:0] e_dato;
        logic       e_ult;
        logic       e_vld;
        logic [2:0] e_cnt;
        logic       e_raf;
        logic       e_desb;
    } vec_t;

    vec_t vq[$];

    lector_bus #(.DATA_W(4), .CS_W(5), .RD_CS(5'b11000), .TURN(1), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .datbus(bus),
        .dato(dato), .dato_ultimo(ult), .dato_valid(vld), .dato_ready(rdy),
        .en_rafaga(raf), .vacio(vacio), .lleno(lleno), .cuenta(cuenta),
        .desborde(desb), .clr_desborde(clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dato"}, int'(dato), 0);
        chk({tag, "_ult"}, int'(ult), 0);
        chk({tag, "_vld"}, int'(vld), 0);
        chk({tag, "_raf"}, int'(raf), 0);
        chk({tag, "_vacio"}, int'(vacio), 1);
        chk({tag, "_lleno"}, int'(lleno), 0);
        chk({tag, "_cuenta"}, int'(cuenta), 0);
        chk({tag, "_desb"}, int'(desb), 0);
    endtask

    initial begin
        // Single-cycle select, drained immediately
        vq.push_back('{RD, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0});
        vq.push_back('{ID, 4'hA, 1'b1, 1'b0, 4'hA, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0});
        vq.push_back('{ID, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
        // Three-word burst held, then drained
        vq.push_back('{RD, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0});
        vq.push_back('{RD, 4'hA, 1'b0, 1'b0, 4'hA, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0});
        vq.push_back('{RD, 4'hB, 1'b0, 1'b0, 4'hA, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0});
        vq.push_back('{ID, 4'hC, 1'b0, 1'b0, 4'hA, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0});
        vq.push_back('{ID, 4'h0, 1'b1, 1'b0, 4'hB, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0});
        vq.push_back('{ID, 4'h0, 1'b1, 1'b0, 4'hC, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0});
        vq.push_back('{ID, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
        // Six-word burst into four slots: overflow, then clear
        vq.push_back('{RD, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0});
        vq.push_back('{RD, 4'h1, 1'b0, 1'b0, 4'h1, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0});
        vq.push_back('{RD, 4'h2, 1'b0, 1'b0, 4'h1, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0});
        vq.push_back('{RD, 4'h3, 1'b0, 1'b0, 4'h1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0});
        vq.push_back('{RD, 4'h4, 1'b0, 1'b0, 4'h1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0});
        vq.push_back('{RD, 4'h5, 1'b0, 1'b0, 4'h1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1});
        vq.push_back('{ID, 4'h6, 1'b0, 1'b0, 4'h1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1});
        vq.push_back('{ID, 4'h0, 1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0});
        // Full FIFO with simultaneous push/pop: no drops
        vq.push_back('{RD, 4'h0, 1'b0, 1'b0, 4'h1, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0});
        vq.push_back('{RD, 4'h7, 1'b1, 1'b0, 4'h2, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0});
        vq.push_back('{RD, 4'h8, 1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0});
        vq.push_back('{RD, 4'h9, 1'b1, 1'b0, 4'h4, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0});
        vq.push_back('{ID, 4'hA, 1'b1, 1'b0, 4'h7, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0});
        vq.push_back('{ID, 4'h0, 1'b1, 1'b0, 4'h8, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0});
        vq.push_back('{ID, 4'h0, 1'b1, 1'b0, 4'h9, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0});
        vq.push_back('{ID, 4'h0, 1'b1, 1'b0, 4'hA, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0});
        vq.push_back('{ID, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});

        // Reset state
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            cs  = vq[i].cs;
            bus = vq[i].bus;
            rdy = vq[i].rdy;
            clr = vq[i].clr;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_dato", i), int'(dato), int'(vq[i].e_dato));
            chk($sformatf("v%0d_ult", i), int'(ult), int'(vq[i].e_ult));
            chk($sformatf("v%0d_vld", i), int'(vld), int'(vq[i].e_vld));
            chk($sformatf("v%0d_cuenta", i), int'(cuenta), int'(vq[i].e_cnt));
            chk($sformatf("v%0d_raf", i), int'(raf), int'(vq[i].e_raf));
            chk($sformatf("v%0d_desb", i), int'(desb), int'(vq[i].e_desb));
            chk($sformatf("v%0d_vacio", i), int'(vacio), int'(vq[i].e_cnt == 3'd0));
            chk($sformatf("v%0d_lleno", i), int'(lleno), int'(vq[i].e_cnt == 3'd4));
        end

        // Non-matching select with a floating bus
        @(negedge clk);
        cs = 5'b11001;
        bus = 'z;
        rdy = 1'b0;
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("nomatch%0d_vacio", i), int'(vacio), 1);
            chk($sformatf("nomatch%0d_raf", i), int'(raf), 0);
        end

        // Async reset in the middle of a burst holding two words
        @(negedge clk);
        cs = RD;
        bus = 4'h0;
        @(negedge clk);
        bus = 4'h1;
        @(negedge clk);
        bus = 4'h2;
        @(posedge clk);
        #1;
        chk("midburst_cuenta", int'(cuenta), 2);
        chk("midburst_raf", int'(raf), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        cs = ID;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst%0d_cuenta", i), int'(cuenta), 0);
            chk($sformatf("post_rst%0d_vld", i), int'(vld), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
